// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: a generic pipeline stage register with a valid/ready handshake.
// It carries a packed data bus and a packed control bus between two stages, and
// replaces fixed-field latches such as IF/ID, ID/EX, EX/MEM and MEM/WB.
// It also provides a stage enable (en), a synchronous flush and a synchronous
// active-high reset.
//
// Build option: define PIPE_STAGE_SKID_EN to add a second (skid) entry. With the
// skid entry, in_ready depends only on registered state and not on out_ready.
// Without it, the stage is a single register and in_ready depends
// combinationally on out_ready.
//
// Parameters: DATA_W (payload width), CTRL_W (control width),
//             FLUSH_ZERO_DATA (1: a flush also clears the stored data).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   en                    stage enable; 0 stops all transfers (flush/reset still apply)
//   flush                 squash every held entry; any entry offered this cycle is dropped
//   in_valid/in_ready     upstream handshake, with in_data / in_ctrl
//   out_valid/out_ready   downstream handshake, with out_data / out_ctrl
//   occupancy             number of held entries (0..2 with skid, 0..1 without)
module pipe_stage_reg #(
    parameter int DATA_W          = 32,
    parameter int CTRL_W          = 16,
    parameter bit FLUSH_ZERO_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              out_ready,
    output logic [1:0]        occupancy
);

    // The main entry always drives the outputs.
    logic              mainValid;
    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] mainCtrl;
    logic              accept;
    logic              drain;

    // en is already part of in_ready; flush has priority over any transfer.
    assign accept = in_valid && in_ready && !flush;
    assign drain  = mainValid && out_ready && en && !flush;

    assign out_valid = mainValid;
    assign out_data  = mainData;
    // out_ctrl is gated so that a stale control word is never presented
    // after the entry has drained.
    assign out_ctrl  = mainValid ? mainCtrl : '0;

`ifdef PIPE_STAGE_SKID_EN
    // The skid entry is valid only while the main entry is valid. It holds
    // the entry that was accepted in the same cycle that out_ready fell.
    logic              skidValid;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] skidCtrl;

    // in_ready is decoded from registered state only. It is 0 when the stage is full.
    assign in_ready  = en && !skidValid;
    assign occupancy = {1'b0, mainValid} + {1'b0, skidValid};

    always_ff @(posedge clk) begin
        if (rst) begin
            mainValid <= 1'b0;
            mainData  <= '0;
            mainCtrl  <= '0;
            skidValid <= 1'b0;
            skidData  <= '0;
            skidCtrl  <= '0;
        end else if (flush) begin
            mainValid <= 1'b0;
            mainCtrl  <= '0;
            skidValid <= 1'b0;
            skidCtrl  <= '0;
            if (FLUSH_ZERO_DATA) begin
                mainData <= '0;
                skidData <= '0;
            end
        end else if (en) begin
            if (!mainValid) begin
                // EMPTY
                if (accept) begin
                    mainValid <= 1'b1;
                    mainData  <= in_data;
                    mainCtrl  <= in_ctrl;
                end
            end else if (!skidValid) begin
                // ONE
                if (accept && drain) begin
                    mainData <= in_data;
                    mainCtrl <= in_ctrl;
                end else if (accept) begin
                    skidValid <= 1'b1;
                    skidData  <= in_data;
                    skidCtrl  <= in_ctrl;
                end else if (drain) begin
                    mainValid <= 1'b0;
                end
            end else begin
                // FULL: no accept is possible; a drain moves skid to main.
                if (drain) begin
                    skidValid <= 1'b0;
                    mainData  <= skidData;
                    mainCtrl  <= skidCtrl;
                end
            end
        end
    end
`else
    // Single register: an entry can be replaced in the same cycle that it drains.
    assign in_ready  = en && (!mainValid || out_ready);
    assign occupancy = {1'b0, mainValid};

    always_ff @(posedge clk) begin
        if (rst) begin
            mainValid <= 1'b0;
            mainData  <= '0;
            mainCtrl  <= '0;
        end else if (flush) begin
            mainValid <= 1'b0;
            mainCtrl  <= '0;
            if (FLUSH_ZERO_DATA) begin
                mainData <= '0;
            end
        end else if (en) begin
            if (accept) begin
                mainValid <= 1'b1;
                mainData  <= in_data;
                mainCtrl  <= in_ctrl;
            end else if (drain) begin
                mainValid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg. Inputs are driven on the falling edge.
// Outputs are checked on the falling edge after the rising edge being tested.
// The skid-only scenarios follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic [15:0] in_ctrl;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [15:0] out_ctrl;
    logic        out_ready;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .FLUSH_ZERO_DATA(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ctrl(out_ctrl),
        .out_ready(out_ready), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then return at the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [15:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    task automatic expOut(input string tag, input logic v, input logic [31:0] d,
                          input logic [15:0] c, input logic [1:0] occ);
        chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
        chk({tag, ".data"},  out_data, d);
        chk({tag, ".ctrl"},  {16'b0, out_ctrl}, {16'b0, c});
        chk({tag, ".occ"},   {30'b0, occupancy}, {30'b0, occ});
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 16'h0);
        @(negedge clk);
        // Inputs offered during reset must be ignored.
        en = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 16'hBEEF);
        tick();
        tick();
        rst = 1'b0;
        en  = 1'b0;
        drive(1'b0, 32'h0, 16'h0);
        tick();
        expOut("reset", 1'b0, 32'h0, 16'h0, 2'd0);
        chk("reset.rdy_en0", {31'b0, in_ready}, 32'd0);
        en = 1'b1;
        #1 chk("reset.rdy_en1", {31'b0, in_ready}, 32'd1);

        // Streaming at full rate.
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_0004, 16'h0003);
        tick();
        expOut("stream0", 1'b1, 32'h4, 16'h3, 2'd1);
        drive(1'b1, 32'h0000_0008, 16'h0005);
        #1 chk("stream.rdy", {31'b0, in_ready}, 32'd1);
        tick();
        expOut("stream1", 1'b1, 32'h8, 16'h5, 2'd1);
        drive(1'b0, 32'h0, 16'h0);
        tick();
        expOut("stream.empty", 1'b0, 32'h8, 16'h0, 2'd0);

`ifdef PIPE_STAGE_SKID_EN
        // Backpressure: the second entry is absorbed by the skid register.
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 16'h1);
        tick();
        expOut("bp.a", 1'b1, 32'h10, 16'h1, 2'd1);
        drive(1'b1, 32'h20, 16'h2);
        #1 chk("bp.rdy1", {31'b0, in_ready}, 32'd1);
        tick();
        expOut("bp.full", 1'b1, 32'h10, 16'h1, 2'd2);
        drive(1'b1, 32'h30, 16'h3);
        #1 chk("bp.rdy0", {31'b0, in_ready}, 32'd0);
        tick();
        expOut("bp.hold", 1'b1, 32'h10, 16'h1, 2'd2);
        drive(1'b0, 32'h0, 16'h0);
        out_ready = 1'b1;
        #1 chk("bp.rdy_full_oready", {31'b0, in_ready}, 32'd0);
        tick();
        expOut("bp.b", 1'b1, 32'h20, 16'h2, 2'd1);
        tick();
        expOut("bp.done", 1'b0, 32'h20, 16'h0, 2'd0);

        // Flush while FULL; data is retained and the offered entry is dropped.
        out_ready = 1'b0;
        drive(1'b1, 32'h30, 16'h7);
        tick();
        drive(1'b1, 32'h40, 16'h9);
        tick();
        expOut("fl.full", 1'b1, 32'h30, 16'h7, 2'd2);
        flush = 1'b1;
        drive(1'b1, 32'h55, 16'hF);
        tick();
        expOut("fl.empty", 1'b0, 32'h30, 16'h0, 2'd0);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 16'h0);
        tick();
        expOut("fl.nodup", 1'b0, 32'h30, 16'h0, 2'd0);
`else
        // Single register: in_ready follows out_ready combinationally.
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 16'h1);
        tick();
        expOut("ns.a", 1'b1, 32'h10, 16'h1, 2'd1);
        drive(1'b1, 32'h20, 16'h2);
        #1 chk("ns.rdy0", {31'b0, in_ready}, 32'd0);
        tick();
        expOut("ns.hold", 1'b1, 32'h10, 16'h1, 2'd1);
        out_ready = 1'b1;
        #1 chk("ns.rdy1", {31'b0, in_ready}, 32'd1);
        tick();
        expOut("ns.repl", 1'b1, 32'h20, 16'h2, 2'd1);
        // Flush with a valid entry; the offered entry is dropped.
        out_ready = 1'b0;
        flush = 1'b1;
        drive(1'b1, 32'h55, 16'hF);
        tick();
        expOut("ns.flush", 1'b0, 32'h20, 16'h0, 2'd0);
        flush = 1'b0;
        drive(1'b0, 32'h0, 16'h0);
        tick();
        expOut("ns.nodup", 1'b0, 32'h20, 16'h0, 2'd0);
`endif

        // Stage enable low freezes state; a flush still applies.
        out_ready = 1'b0;
        drive(1'b1, 32'h66, 16'h4);
        tick();
        expOut("en.load", 1'b1, 32'h66, 16'h4, 2'd1);
        en = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h77, 16'h8);
        for (int i = 0; i < 3; i++) begin
            #1 chk("en.rdy0", {31'b0, in_ready}, 32'd0);
            tick();
            expOut("en.frozen", 1'b1, 32'h66, 16'h4, 2'd1);
        end
        flush = 1'b1;
        tick();
        expOut("en.flush", 1'b0, 32'h66, 16'h0, 2'd0);
        flush = 1'b0;
        en = 1'b1;

        // Reset and flush together: the reset behavior applies and data is cleared.
        out_ready = 1'b0;
        drive(1'b1, 32'h99, 16'h6);
        tick();
        expOut("rf.load", 1'b1, 32'h99, 16'h6, 2'd1);
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 16'h0);
        expOut("rf.clear", 1'b0, 32'h0, 16'h0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
